// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the sync_fifo family: default geometry, the pointer
// width helper and a bundled status type for consumers that carry the flags
// as one signal.
package sync_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    // Pointer width for a given depth; a depth of 1 still needs one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param. The master side drives the
// requests and write data; the slave side (the FIFO) returns data, occupancy
// and status.
interface sync_fifo_param_if import sync_fifo_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int AW = ptr_width(DEPTH);

    logic             wr;
    logic [WIDTH-1:0] d;
    logic             rd;
    logic [WIDTH-1:0] q;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr, d, rd,
        input  q, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr, d, rd,
        output q, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_ram.sv
// DEPTH x WIDTH storage with one synchronous write port and one asynchronous
// read port. Any read register lives in the instantiating module.
module sync_fifo_ram import sync_fifo_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [ptr_width(DEPTH)-1:0]    waddr,
    input  logic [WIDTH-1:0]               wdata,
    input  logic [ptr_width(DEPTH)-1:0]    raddr,
    output logic [WIDTH-1:0]               rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on an accepted write.
    // NOTE: the array has no reset; clearing it would force a flop-based
    // implementation, and occupancy tracking already hides stale entries.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, almost-full/almost-empty
// thresholds and one-cycle overflow/underflow pulses.
// Compile-time option SYNC_FIFO_FWFT_EN: when defined, q is first-word-fall-
// through (head word shown combinationally, 0 when empty); when undefined, q
// is a register loaded on each accepted read and held otherwise.
// Reset is synchronous and active-low on rst.
module sync_fifo_param import sync_fifo_pkg::*; #(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_param_if.slave  bus
);
    localparam int AW = ptr_width(DEPTH);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_AF   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] CNT_AE   = (AW+1)'(AE_LEVEL);

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wa, ra, we;
    logic [WIDTH-1:0] rdata;
    fifo_status_t     status;

    // Flags are pure decodes of the occupancy register.
    always_comb begin
        status.full         = (count_q == CNT_FULL);
        status.empty        = (count_q == '0);
        status.almost_full  = (count_q >= CNT_AF);
        status.almost_empty = (count_q <= CNT_AE);
    end

    // Acceptance is judged on the pre-edge flags only.
    assign wa = bus.wr & ~status.full;
    assign ra = bus.rd & ~status.empty;
    assign we = wa & rst;

    // Next pointers, occupancy and error pulses; reset folds in here.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (!rst) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wa) wptr_d = wptr_q + 1'b1;
            if (ra) rptr_d = rptr_q + 1'b1;
            case ({wa, ra})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            overflow_d  = bus.wr & status.full;
            underflow_d = bus.rd & status.empty;
        end
    end

    // State register for pointers, occupancy and error pulses.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        wptr_q      <= wptr_d;
        rptr_q      <= rptr_d;
        count_q     <= count_d;
        overflow_q  <= overflow_d;
        underflow_q <= underflow_d;
    end

    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr_q),
        .wdata (bus.d),
        .raddr (rptr_q),
        .rdata (rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.q = status.empty ? '0 : rdata;
`else
    logic [WIDTH-1:0] q_q, q_d;

    // Registered read data: load the head word on an accepted read, else hold.
    always_comb begin
        q_d = q_q;
        if (!rst) begin
            q_d = '0;
        end else if (ra) begin
            q_d = rdata;
        end
    end

    // Read data register.
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign bus.q = q_q;
`endif

    assign bus.full         = status.full;
    assign bus.empty        = status.empty;
    assign bus.almost_full  = status.almost_full;
    assign bus.almost_empty = status.almost_empty;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
